mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/rv32ima_pkg.sv | 33 +++
 rtl/mem_lane_align.sv | 39 +++
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/rv32ima_pkg.sv
// Shared types for the memory arbiter: FSM states, access widths and decode helpers.
package rv32ima_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_width_t;

  // Both 2'b10 and 2'b11 encode a full word.
  function automatic mem_width_t decode_width(input logic [1:0] w);
    case (w)
      2'b00:   return BYTE;
      2'b01:   return HALF;
      default: return WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input mem_width_t w, input logic [1:0] a);
    case (w)
      BYTE:    return 1'b0;
      HALF:    return a[0];
      default: return (a != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: write strobes, store-data replication and load shift/mask.
module mem_lane_align
  import rv32ima_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  mem_width_t  i_width,
  input  logic        i_is_write,
  input  logic [31:0] i_store,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load
);

  logic [31:0] w_shifted;

  always_comb begin
    w_shifted = i_rdata >> {i_addr_lo, 3'b000};
    o_wstrb   = 4'b1111;
    o_wdata   = i_store;
    o_load    = w_shifted;
    case (i_width)
      BYTE: begin
        o_wstrb = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_store[7:0]}};
        o_load  = {24'h0, w_shifted[7:0]};
      end
      HALF: begin
        o_wstrb = 4'b0011 << i_addr_lo;
        o_wdata = {2{i_store[15:0]}};
        o_load  = {16'h0, w_shifted[15:0]};
      end
      default: ;
    endcase
    // Reads never assert any byte enable.
    if (!i_is_write) o_wstrb = 4'b0000;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single RAM port with an IDLE->BUSY->RESP FSM.
// Optional BUSY timeout is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import rv32ima_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_ren,
  input  logic [31:0] imem_addr,
  input  logic        dmem_ren,
  input  logic        dmem_wen,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_store,
  input  logic [1:0]  dmem_width,
  output logic        ihit,
  output logic [31:0] imem_load,
  output logic        dhit,
  output logic [31:0] dmem_load,
  output logic        fault,
  output logic        ram_req,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [3:0]  ram_wstrb,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ack,
  output arb_state_t  dbg_state
);

  // Handshake: ram_req stays high with stable addr/we/wstrb/wdata for the whole
  // BUSY state; a single-cycle ram_ack while BUSY completes the access.

  arb_state_t r_state, w_next;
  logic [31:0] r_addr, r_store, r_imem_load, r_dmem_load;
  mem_width_t  r_width;
  logic        r_we, r_is_d, r_fault;
  logic        w_d_req, w_d_mis, w_timeout;
  mem_width_t  w_d_width;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata, w_load;

  assign w_d_req   = dmem_ren | dmem_wen;
  assign w_d_width = decode_width(dmem_width);
  assign w_d_mis   = is_misaligned(w_d_width, dmem_addr[1:0]);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] r_busy_cnt;

  always_ff @(posedge clk) begin
    if (rst || r_state != BUSY) r_busy_cnt <= '0;
    else                        r_busy_cnt <= r_busy_cnt + 1'b1;
  end

  assign w_timeout = (r_state == BUSY) && (r_busy_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  mem_lane_align u_lane (
    .i_addr_lo  (r_addr[1:0]),
    .i_width    (r_width),
    .i_is_write (r_we),
    .i_store    (r_store),
    .i_rdata    (ram_rdata),
    .o_wstrb    (w_wstrb),
    .o_wdata    (w_wdata),
    .o_load     (w_load)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_d_req)       w_next = w_d_mis ? RESP : BUSY;
        else if (imem_ren) w_next = BUSY;
      end
      BUSY:    if (ram_ack || w_timeout) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_store     <= '0;
      r_width     <= WORD;
      r_we        <= 1'b0;
      r_is_d      <= 1'b0;
      r_fault     <= 1'b0;
      r_imem_load <= '0;
      r_dmem_load <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (w_d_req) begin
            r_addr  <= dmem_addr;
            r_store <= dmem_store;
            r_width <= w_d_width;
            r_we    <= dmem_wen;
            r_is_d  <= 1'b1;
            r_fault <= w_d_mis;
            if (w_d_mis) r_dmem_load <= '0;
          end else if (imem_ren) begin
            r_addr  <= imem_addr & 32'hFFFF_FFFC;
            r_store <= '0;
            r_width <= WORD;
            r_we    <= 1'b0;
            r_is_d  <= 1'b0;
            r_fault <= 1'b0;
          end
        end
        BUSY: begin
          if (ram_ack) begin
            r_fault <= 1'b0;
            if (!r_is_d)   r_imem_load <= w_load;
            else if (!r_we) r_dmem_load <= w_load;
          end else if (w_timeout) begin
            r_fault <= 1'b1;
            if (r_is_d) r_dmem_load <= '0;
            else        r_imem_load <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign ram_req   = (r_state == BUSY);
  assign ram_we    = ram_req & r_we;
  assign ram_addr  = {r_addr[31:2], 2'b00};
  assign ram_wstrb = ram_req ? w_wstrb : 4'b0000;
  assign ram_wdata = w_wdata;
  assign ihit      = (r_state == RESP) & ~r_is_d;
  assign dhit      = (r_state == RESP) & r_is_d;
  assign fault     = (r_state == RESP) & r_fault;
  assign imem_load = r_imem_load;
  assign dmem_load = r_dmem_load;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: reset, fetch, priority, stores, loads, faults.
module tb_mem_arbiter;
  import rv32ima_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_ren = 1'b0;
  logic [31:0] imem_addr = '0;
  logic        dmem_ren = 1'b0;
  logic        dmem_wen = 1'b0;
  logic [31:0] dmem_addr = '0;
  logic [31:0] dmem_store = '0;
  logic [1:0]  dmem_width = 2'b10;
  logic [31:0] ram_rdata = '0;
  logic        ram_ack = 1'b0;
  logic        ihit, dhit, fault, ram_req, ram_we;
  logic [31:0] imem_load, dmem_load, ram_addr, ram_wdata;
  logic [3:0]  ram_wstrb;
  arb_state_t  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .imem_ren(imem_ren), .imem_addr(imem_addr),
    .dmem_ren(dmem_ren), .dmem_wen(dmem_wen), .dmem_addr(dmem_addr),
    .dmem_store(dmem_store), .dmem_width(dmem_width),
    .ihit(ihit), .imem_load(imem_load), .dhit(dhit), .dmem_load(dmem_load),
    .fault(fault), .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wstrb(ram_wstrb), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .ram_ack(ram_ack), .dbg_state(dbg_state)
  );

  // Driver: advance one clock; inputs change and outputs are sampled at negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_req();
    imem_ren = 1'b0; dmem_ren = 1'b0; dmem_wen = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    n_cmp++; if (dbg_state !== IDLE) begin n_bad++; $display("FAIL rst_state: got %0d want %0d", dbg_state, IDLE); end
    n_cmp++; if (ram_req !== 1'b0) begin n_bad++; $display("FAIL rst_ram_req: got %b want 0", ram_req); end
    n_cmp++; if (ram_we !== 1'b0) begin n_bad++; $display("FAIL rst_ram_we: got %b want 0", ram_we); end
    n_cmp++; if (ram_wstrb !== 4'b0000) begin n_bad++; $display("FAIL rst_wstrb: got %b want 0000", ram_wstrb); end
    n_cmp++; if ({ihit, dhit, fault} !== 3'b000) begin n_bad++; $display("FAIL rst_hits: got %b want 000", {ihit, dhit, fault}); end
    n_cmp++; if (imem_load !== 32'h0) begin n_bad++; $display("FAIL rst_imem_load: got %h want 0", imem_load); end
    n_cmp++; if (dmem_load !== 32'h0) begin n_bad++; $display("FAIL rst_dmem_load: got %h want 0", dmem_load); end
  endtask

  task automatic test_fetch();
    imem_ren = 1'b1; imem_addr = 32'h0000_0103;
    step();
    clear_req();
    n_cmp++; if (ram_req !== 1'b1) begin n_bad++; $display("FAIL fetch_req: got %b want 1", ram_req); end
    n_cmp++; if (ram_addr !== 32'h0000_0100) begin n_bad++; $display("FAIL fetch_addr: got %h want 00000100", ram_addr); end
    n_cmp++; if ({ram_we, ram_wstrb} !== 5'b0_0000) begin n_bad++; $display("FAIL fetch_we_strb: got %b want 00000", {ram_we, ram_wstrb}); end
    ram_ack = 1'b1; ram_rdata = 32'h0013_0093;
    step();
    ram_ack = 1'b0;
    n_cmp++; if ({ihit, dhit, fault} !== 3'b100) begin n_bad++; $display("FAIL fetch_hit: got %b want 100", {ihit, dhit, fault}); end
    n_cmp++; if (imem_load !== 32'h0013_0093) begin n_bad++; $display("FAIL fetch_load: got %h want 00130093", imem_load); end
    n_cmp++; if (ram_req !== 1'b0) begin n_bad++; $display("FAIL fetch_req_resp: got %b want 0", ram_req); end
    ram_rdata = 32'hDEAD_BEEF;
    step();
    n_cmp++; if (ihit !== 1'b0) begin n_bad++; $display("FAIL fetch_hit_once: got %b want 0", ihit); end
    n_cmp++; if (imem_load !== 32'h0013_0093) begin n_bad++; $display("FAIL fetch_load_hold: got %h want 00130093", imem_load); end
  endtask

  task automatic test_priority();
    imem_ren = 1'b1; imem_addr = 32'h20;
    dmem_ren = 1'b1; dmem_addr = 32'h20; dmem_width = 2'b10;
    step();
    dmem_ren = 1'b0;
    n_cmp++; if (ram_addr !== 32'h20 || ram_req !== 1'b1) begin n_bad++; $display("FAIL prio_busy: got req %b addr %h want 1 00000020", ram_req, ram_addr); end
    ram_ack = 1'b1; ram_rdata = 32'h1122_3344;
    step();
    ram_ack = 1'b0;
    n_cmp++; if ({ihit, dhit} !== 2'b01) begin n_bad++; $display("FAIL prio_data_first: got ihit/dhit %b want 01", {ihit, dhit}); end
    n_cmp++; if (dmem_load !== 32'h1122_3344) begin n_bad++; $display("FAIL prio_dload: got %h want 11223344", dmem_load); end
    step();
    n_cmp++; if (dbg_state !== IDLE || ram_req !== 1'b0) begin n_bad++; $display("FAIL prio_gap: got state %0d req %b want 0 0", dbg_state, ram_req); end
    step();
    imem_ren = 1'b0;
    n_cmp++; if (ram_req !== 1'b1) begin n_bad++; $display("FAIL prio_fetch_req: got %b want 1", ram_req); end
    ram_ack = 1'b1; ram_rdata = 32'h5566_7788;
    step();
    ram_ack = 1'b0;
    n_cmp++; if ({ihit, dhit} !== 2'b10) begin n_bad++; $display("FAIL prio_fetch_hit: got ihit/dhit %b want 10", {ihit, dhit}); end
    n_cmp++; if (imem_load !== 32'h5566_7788) begin n_bad++; $display("FAIL prio_iload: got %h want 55667788", imem_load); end
    n_cmp++; if (dmem_load !== 32'h1122_3344) begin n_bad++; $display("FAIL prio_dload_hold: got %h want 11223344", dmem_load); end
    step();
  endtask

  task automatic test_stores();
    logic [31:0] exp_data [3] = '{32'hABAB_ABAB, 32'h1234_1234, 32'hCAFE_F00D};
    logic [3:0]  exp_strb [3] = '{4'b0100, 4'b1100, 4'b1111};
    logic [31:0] addrs    [3] = '{32'h42, 32'h42, 32'h44};
    logic [31:0] stores   [3] = '{32'h0000_00AB, 32'h0000_1234, 32'hCAFE_F00D};
    logic [1:0]  widths   [3] = '{2'b00, 2'b01, 2'b11};
    for (int i = 0; i < 3; i++) begin
      dmem_wen = 1'b1; dmem_ren = (i == 2); // last case: write wins over read
      dmem_addr = addrs[i]; dmem_store = stores[i]; dmem_width = widths[i];
      step();
      clear_req();
      dmem_store = 32'hFFFF_FFFF;
      n_cmp++; if (ram_we !== 1'b1) begin n_bad++; $display("FAIL st%0d_we: got %b want 1", i, ram_we); end
      n_cmp++; if (ram_wstrb !== exp_strb[i]) begin n_bad++; $display("FAIL st%0d_strb: got %b want %b", i, ram_wstrb, exp_strb[i]); end
      n_cmp++; if (ram_wdata !== exp_data[i]) begin n_bad++; $display("FAIL st%0d_wdata: got %h want %h", i, ram_wdata, exp_data[i]); end
      n_cmp++; if (ram_addr !== {addrs[i][31:2], 2'b00}) begin n_bad++; $display("FAIL st%0d_addr: got %h want %h", i, ram_addr, {addrs[i][31:2], 2'b00}); end
      ram_ack = 1'b1;
      step();
      ram_ack = 1'b0;
      n_cmp++; if ({dhit, fault} !== 2'b10) begin n_bad++; $display("FAIL st%0d_dhit: got dhit/fault %b want 10", i, {dhit, fault}); end
      step();
    end
  endtask

  task automatic test_loads();
    logic [31:0] addrs [3] = '{32'h42, 32'h43, 32'h48};
    logic [1:0]  widths[3] = '{2'b01, 2'b00, 2'b10};
    logic [31:0] rdata [3] = '{32'hBEEF_1234, 32'hBEEF_1234, 32'h8765_4321};
    logic [31:0] exp   [3] = '{32'h0000_BEEF, 32'h0000_00BE, 32'h8765_4321};
    for (int i = 0; i < 3; i++) begin
      dmem_ren = 1'b1; dmem_addr = addrs[i]; dmem_width = widths[i];
      step();
      clear_req();
      n_cmp++; if ({ram_req, ram_we, ram_wstrb} !== 6'b10_0000) begin n_bad++; $display("FAIL ld%0d_req: got %b want 100000", i, {ram_req, ram_we, ram_wstrb}); end
      ram_ack = 1'b1; ram_rdata = rdata[i];
      step();
      ram_ack = 1'b0;
      n_cmp++; if ({dhit, fault} !== 2'b10) begin n_bad++; $display("FAIL ld%0d_dhit: got %b want 10", i, {dhit, fault}); end
      n_cmp++; if (dmem_load !== exp[i]) begin n_bad++; $display("FAIL ld%0d_data: got %h want %h", i, dmem_load, exp[i]); end
      step();
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] addrs [2] = '{32'h41, 32'h45};
    logic [1:0]  widths[2] = '{2'b10, 2'b01};
    for (int i = 0; i < 2; i++) begin
      dmem_ren = 1'b1; dmem_addr = addrs[i]; dmem_width = widths[i];
      step();
      clear_req();
      n_cmp++; if (ram_req !== 1'b0) begin n_bad++; $display("FAIL mis%0d_req: got %b want 0", i, ram_req); end
      n_cmp++; if ({dhit, fault} !== 2'b11) begin n_bad++; $display("FAIL mis%0d_fault: got dhit/fault %b want 11", i, {dhit, fault}); end
      n_cmp++; if (dmem_load !== 32'h0) begin n_bad++; $display("FAIL mis%0d_load: got %h want 0", i, dmem_load); end
      step();
      n_cmp++; if ({dhit, fault} !== 2'b00) begin n_bad++; $display("FAIL mis%0d_clear: got %b want 00", i, {dhit, fault}); end
    end
  endtask

  task automatic test_stray_ack();
    ram_ack = 1'b1; ram_rdata = 32'h7777_7777;
    step();
    ram_ack = 1'b0;
    n_cmp++; if (dbg_state !== IDLE || {ihit, dhit} !== 2'b00) begin n_bad++; $display("FAIL stray_ack: got state %0d hits %b want 0 00", dbg_state, {ihit, dhit}); end
  endtask

  task automatic test_busy_wait_and_reset();
    int busy_cycles = 0;
    int saw_hit = 0;
    dmem_ren = 1'b1; dmem_addr = 32'h80; dmem_width = 2'b10;
    step();
    clear_req();
    for (int c = 0; c < 10; c++) begin
      if (ram_req) busy_cycles++;
      if (dhit) saw_hit++;
      if (!ram_req) break;
      step();
    end
`ifdef MEM_ARB_TIMEOUT_EN
    n_cmp++; if (busy_cycles != 4) begin n_bad++; $display("FAIL to_busy_cycles: got %0d want 4", busy_cycles); end
    n_cmp++; if ({dhit, fault} !== 2'b11) begin n_bad++; $display("FAIL to_fault: got dhit/fault %b want 11", {dhit, fault}); end
    n_cmp++; if (dmem_load !== 32'h0) begin n_bad++; $display("FAIL to_load: got %h want 0", dmem_load); end
    step();
    dmem_ren = 1'b1;
    step();
    clear_req();
`else
    n_cmp++; if (busy_cycles != 10 || saw_hit != 0) begin n_bad++; $display("FAIL wait_forever: got busy %0d hits %0d want 10 0", busy_cycles, saw_hit); end
`endif
    n_cmp++; if (ram_req !== 1'b1) begin n_bad++; $display("FAIL rst_mid_pre: got req %b want 1", ram_req); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if (dbg_state !== IDLE || {ram_req, ram_we, ihit, dhit, fault} !== 5'b0) begin n_bad++; $display("FAIL rst_mid_busy: got state %0d outs %b want 0 00000", dbg_state, {ram_req, ram_we, ihit, dhit, fault}); end
    n_cmp++; if ({ram_wstrb, imem_load, dmem_load} !== 68'h0) begin n_bad++; $display("FAIL rst_mid_data: got %h want 0", {ram_wstrb, imem_load, dmem_load}); end
    ram_ack = 1'b1; ram_rdata = 32'h1234_5678;
    step();
    ram_ack = 1'b0;
    n_cmp++; if (dbg_state !== IDLE || {ihit, dhit} !== 2'b00 || dmem_load !== 32'h0) begin n_bad++; $display("FAIL late_ack: got state %0d hits %b load %h want 0 00 0", dbg_state, {ihit, dhit}, dmem_load); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_fetch();
    test_priority();
    test_stores();
    test_loads();
    test_misaligned();
    test_stray_ack();
    test_busy_wait_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
